// File: rtl/gb_bus_pkg.sv
// Shared Game Boy bus types: arbiter state encoding, DMA owner enum and GAP length.
package gb_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_OAM  = 2'd2,
    ST_HDMA = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_OAM  = 2'd1,
    OWN_HDMA = 2'd2
  } owner_t;

  localparam int unsigned GAP_LEN = 1;

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// Bus-side signals of the DMA bus arbiter: requester inputs, grants, muxed bus and FSM debug state.
// Handshake: oam_req/hdma_req are level-held for a whole transfer; a grant (registered) means the
// requester owns the bus that ce cycle; dropping req releases it through a one-cycle GAP.
interface dma_bus_arbiter_if;
  import gb_bus_pkg::*;

  logic        cpu_req;
  logic        cpu_rd;
  logic [15:0] cpu_addr;
  logic [15:0] oam_addr;
  logic [15:0] hdma_addr;
  logic        oam_req;
  logic        hdma_req;
  logic        gnt_cpu;
  logic        gnt_oam;
  logic        gnt_hdma;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        cpu_stall;
  arb_state_t  state_dbg;

  modport master (
    output cpu_req, cpu_rd, cpu_addr, oam_addr, hdma_addr, oam_req, hdma_req,
    input  gnt_cpu, gnt_oam, gnt_hdma, bus_addr, bus_rd, cpu_stall, state_dbg
  );

  modport slave (
    input  cpu_req, cpu_rd, cpu_addr, oam_addr, hdma_addr, oam_req, hdma_req,
    output gnt_cpu, gnt_oam, gnt_hdma, bus_addr, bus_rd, cpu_stall, state_dbg
  );

endinterface

// File: rtl/dma_bus_arbiter.sv
// CPU / OAM DMA / HDMA bus arbiter with a turnaround GAP between owners.
// Define DMA_ARB_ROUND_ROBIN_EN to alternate the winner of simultaneous DMA requests.
module dma_bus_arbiter
  import gb_bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  dma_bus_arbiter_if.slave  bus
);

  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  arb_state_t  state, state_nx;
  owner_t      next_owner, next_owner_nx;
  owner_t      pick;
  logic [GW-1:0] gap_cnt;
  logic        gap_done;
  logic [15:0] addr_q, addr_nx;
  logic        rd_q, rd_nx;

  assign gap_done = (gap_cnt == GW'(GAP_LEN - 1));

`ifdef DMA_ARB_ROUND_ROBIN_EN
  logic last_hdma;

  always_comb begin
    pick = OWN_NONE;
    if (bus.hdma_req && bus.oam_req) pick = last_hdma ? OWN_OAM : OWN_HDMA;
    else if (bus.hdma_req)           pick = OWN_HDMA;
    else if (bus.oam_req)            pick = OWN_OAM;
  end

  // Only an IDLE selection counts as a win; OAM<->HDMA hand-offs do not.
  always_ff @(posedge clk) begin
    if (reset)                                         last_hdma <= 1'b0;
    else if (ce && state == ST_IDLE && pick != OWN_NONE) last_hdma <= (pick == OWN_HDMA);
  end
`else
  always_comb begin
    pick = OWN_NONE;
    if (bus.hdma_req)     pick = OWN_HDMA;
    else if (bus.oam_req) pick = OWN_OAM;
  end
`endif

  always_comb begin
    state_nx      = state;
    next_owner_nx = next_owner;
    case (state)
      ST_IDLE: begin
        if (pick != OWN_NONE) begin
          state_nx      = ST_GAP;
          next_owner_nx = pick;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          next_owner_nx = OWN_NONE;
          // A latched owner that gave up its request is skipped in favour of the other DMA.
          case (next_owner)
            OWN_HDMA: state_nx = bus.hdma_req ? ST_HDMA : (bus.oam_req  ? ST_OAM  : ST_IDLE);
            OWN_OAM:  state_nx = bus.oam_req  ? ST_OAM  : (bus.hdma_req ? ST_HDMA : ST_IDLE);
            default:  state_nx = ST_IDLE;
          endcase
        end
      end
      ST_OAM: begin
        if (!bus.oam_req) begin
          state_nx      = ST_GAP;
          next_owner_nx = bus.hdma_req ? OWN_HDMA : OWN_NONE;
        end
      end
      ST_HDMA: begin
        if (!bus.hdma_req) begin
          state_nx      = ST_GAP;
          next_owner_nx = bus.oam_req ? OWN_OAM : OWN_NONE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Bus outputs are registered alongside the state so they line up with the grants.
  always_comb begin
    addr_nx = addr_q;
    rd_nx   = 1'b0;
    case (state_nx)
      ST_IDLE: begin
        if (bus.cpu_req) addr_nx = bus.cpu_addr;
        rd_nx = bus.cpu_rd;
      end
      ST_OAM: begin
        addr_nx = bus.oam_addr;
        rd_nx   = 1'b1;
      end
      ST_HDMA: begin
        addr_nx = bus.hdma_addr;
        rd_nx   = 1'b1;
      end
      default: begin
        addr_nx = addr_q;
        rd_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      next_owner <= OWN_NONE;
      gap_cnt    <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
    end else if (ce) begin
      state      <= state_nx;
      next_owner <= next_owner_nx;
      gap_cnt    <= (state == ST_GAP && !gap_done) ? gap_cnt + 1'b1 : '0;
      addr_q     <= addr_nx;
      rd_q       <= rd_nx;
    end
  end

  assign bus.gnt_cpu   = (state == ST_IDLE);
  assign bus.gnt_oam   = (state == ST_OAM);
  assign bus.gnt_hdma  = (state == ST_HDMA);
  assign bus.cpu_stall = (state != ST_IDLE);
  assign bus.bus_addr  = addr_q;
  assign bus.bus_rd    = rd_q;
  assign bus.state_dbg = state;

endmodule
